// File: rtl/native_arb_pkg.sv
// Shared definitions for the native FIFO round-robin arbiter: FSM encoding
// and the round-robin pointer width helper.
package native_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int ARB_MIN_PTR_W = 1;

    function automatic int arb_ptr_width(input int n);
        return ($clog2(n) < ARB_MIN_PTR_W) ? ARB_MIN_PTR_W : $clog2(n);
    endfunction

endpackage

// File: rtl/native_fifo_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: one-hot first requester found scanning
// upward from ptr_i, wrapping modulo NumInputs.
module rr_priority_picker
    import native_arb_pkg::*;
#(
    parameter int NumInputs = 4,
    parameter int PtrW      = arb_ptr_width(NumInputs)
) (
    input  logic [NumInputs-1:0] req_i,
    input  logic [PtrW-1:0]      ptr_i,
    output logic [NumInputs-1:0] win_o
);

    logic [PtrW:0]   sum;
    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NumInputs; k++) begin
            sum = {1'b0, ptr_i} + (PtrW+1)'(k);
            if (sum >= (PtrW+1)'(NumInputs)) begin
                sum = sum - (PtrW+1)'(NumInputs);
            end
            idx = sum[PtrW-1:0];
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/native_fifo_rr_arbiter.sv
// Round-robin arbiter from N first-word-fall-through FIFOs onto one registered
// AXI4-Stream output. Define NATIVE_ARB_PKT_LOCK_EN to hold ownership per packet.
module native_fifo_rr_arbiter
    import native_arb_pkg::*;
#(
    parameter int NumInputs   = 4,
    parameter int STDataWidth = 32,
    parameter int TidWidth    = 8,
    parameter int TdestWidth  = 8
) (
    input  logic                              aclk,
    input  logic                              arstn,
    input  logic [NumInputs*TidWidth-1:0]     s_native_tid,
    input  logic [NumInputs*TdestWidth-1:0]   s_native_tdest,
    input  logic [NumInputs*STDataWidth-1:0]  s_native_tdata,
    input  logic [NumInputs-1:0]              s_native_tlast,
    input  logic [NumInputs-1:0]              s_native_tvalid,
    output logic [NumInputs-1:0]              s_native_tready,
    output logic [TidWidth-1:0]               m_axis_tid,
    output logic [TdestWidth-1:0]             m_axis_tdest,
    output logic [STDataWidth-1:0]            m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [NumInputs-1:0]              grant
);

    localparam int PtrW = arb_ptr_width(NumInputs);

    arb_state_e             state_q, state_d;
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NumInputs-1:0]   grant_q, grant_d;
    logic [TidWidth-1:0]    tid_q, tid_d;
    logic [TdestWidth-1:0]  tdest_q, tdest_d;
    logic [STDataWidth-1:0] tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;

    logic [NumInputs-1:0]   win;
    logic [PtrW-1:0]        g_idx;
    logic [TidWidth-1:0]    sel_tid;
    logic [TdestWidth-1:0]  sel_tdest;
    logic [STDataWidth-1:0] sel_tdata;
    logic                   sel_tlast;
    logic                   ld;
    logic                   pop;
    logic                   end_beat;

    rr_priority_picker #(
        .NumInputs (NumInputs),
        .PtrW      (PtrW)
    ) u_picker (
        .req_i (s_native_tvalid),
        .ptr_i (rr_ptr_q),
        .win_o (win)
    );

    // grant_q is one-hot or zero, so the OR of matches is the owner's slice.
    always_comb begin
        g_idx     = '0;
        sel_tid   = '0;
        sel_tdest = '0;
        sel_tdata = '0;
        sel_tlast = 1'b0;
        for (int i = 0; i < NumInputs; i++) begin
            if (grant_q[i]) begin
                g_idx     = PtrW'(i);
                sel_tid   = s_native_tid[i*TidWidth +: TidWidth];
                sel_tdest = s_native_tdest[i*TdestWidth +: TdestWidth];
                sel_tdata = s_native_tdata[i*STDataWidth +: STDataWidth];
                sel_tlast = s_native_tlast[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        tid_d           = tid_q;
        tdest_d         = tdest_q;
        tdata_d         = tdata_q;
        tlast_d         = tlast_q;
        tvalid_d        = tvalid_q;
        s_native_tready = '0;
        pop             = 1'b0;
        end_beat        = 1'b0;
        ld              = !tvalid_q || m_axis_tready;

        case (state_q)
            ARB_IDLE: begin
                if (|s_native_tvalid) begin
                    grant_d = win;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                s_native_tready = grant_q & s_native_tvalid & {NumInputs{ld}};
                pop             = |s_native_tready;
`ifdef NATIVE_ARB_PKT_LOCK_EN
                end_beat        = pop && sel_tlast;
`else
                end_beat        = pop;
`endif
                if (end_beat) begin
                    rr_ptr_d = (g_idx == PtrW'(NumInputs-1)) ? '0 : g_idx + PtrW'(1);
                    grant_d  = '0;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // The output register only advances when empty or being drained.
        if (ld) begin
            tvalid_d = pop;
            if (pop) begin
                tid_d   = sel_tid;
                tdest_d = sel_tdest;
                tdata_d = sel_tdata;
                tlast_d = sel_tlast;
            end
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            tid_q    <= '0;
            tdest_q  <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign grant         = grant_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tdest  = tdest_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: doc/native_fifo_rr_arbiter.md
# native_fifo_rr_arbiter

Packet-aware round-robin arbiter that shares one AXI4-Stream (reduced subset) output between NumInputs native-flow-control FIFOs operating in first-word-fall-through mode. It pops the granted FIFO with a per-input read strobe and drives a single registered m_axis stream. It sits between the per-port input FIFOs and the downstream AXI-Stream consumer, for example a router output port or a network interface injection path.

## Interface
- NumInputs, 4: number of requesting FIFOs, ≥2.
- STDataWidth, 32: tdata width in bits.
- TidWidth, 8: tid width.
- TdestWidth, 8: tdest width.
- aclk  in  1  clock; all logic rising-edge.
- arstn  in  1  reset; asynchronous, active-low.
- s_native_tid  in  NumInputs*TidWidth  per-input tid; input i occupies slice [i*TidWidth +: TidWidth].
- s_native_tdest  in  NumInputs*TdestWidth  per-input tdest; same slicing rule.
- s_native_tdata  in  NumInputs*STDataWidth  per-input tdata; same slicing rule.
- s_native_tlast  in  NumInputs  per-input end-of-packet flag.
- s_native_tvalid  in  NumInputs  per-input FIFO not-empty.
- s_native_tready  out  NumInputs  per-input read strobe; one-hot or zero.
- m_axis_tid  out  TidWidth  registered tid.
- m_axis_tdest  out  TdestWidth  registered tdest.
- m_axis_tdata  out  STDataWidth  registered tdata.
- m_axis_tlast  out  1  registered tlast.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts the beat.
- grant  out  NumInputs  one-hot current owner; zero in IDLE.

## Operation
- Two-state FSM:
  - IDLE: no owner.
  - LOCK: an input owns the output.
- Round-robin pointer rr_ptr, width $clog2(NumInputs); reset value 0.
- In IDLE with any s_native_tvalid set:
  - Winner is the first valid input scanning rr_ptr, rr_ptr+1, … mod NumInputs.
  - grant is set to the winner one-hot, and the FSM moves to LOCK the next cycle.
- In IDLE with no valid input: the FSM stays in IDLE.
- Load enable: ld = !m_axis_tvalid || m_axis_tready.
- In LOCK:
  - s_native_tready[g] = ld && s_native_tvalid[g]; all other strobes are 0.
  - A pop copies input g's tid/tdest/tdata/tlast into the output register and sets m_axis_tvalid.
  - When ld is true and there is no pop, m_axis_tvalid clears.
- Packet end: a popped beat with tlast=1 sets rr_ptr to (g+1) mod NumInputs, clears grant and returns the FSM to IDLE.
- Stall conditions:
  - If the granted input deasserts tvalid mid-packet, ownership is kept, no pop occurs and the state is held indefinitely.
  - If m_axis_tready is low while m_axis_tvalid is high, the output register, grant and all strobes hold, and nothing is popped.
- Non-granted inputs are never popped. s_native_tvalid changes on non-granted inputs have no effect during LOCK.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tid/tdest/tdata=0, s_native_tready=0, grant=0, FSM=IDLE, rr_ptr=0.
- Latency:
  - Input valid in IDLE at cycle 0 → grant at cycle 1.
  - First pop at cycle 1 → m_axis_tvalid at cycle 2.
- Steady state: 1 beat per cycle while the owner is valid and m_axis_tready=1.
- Arbitration bubble: one idle cycle between packets.
- An arstn assertion mid-packet immediately clears all state to the reset values. The partial packet is not completed, and the next grant restarts from input 0.

## Configuration
- NATIVE_ARB_PKT_LOCK_EN defined:
  - Ownership is held until the tlast beat, as described in Operation.
- NATIVE_ARB_PKT_LOCK_EN undefined:
  - Beat-level round-robin: every popped beat returns the FSM to IDLE and sets rr_ptr to g+1, regardless of tlast.
  - tlast is passed through unchanged.

## Structure
- Shared package native_arb_pkg holds:
  - FSM state encoding: ARB_IDLE, ARB_LOCK.
  - Pointer-width helper constant.
- One sub-module, rr_priority_picker: combinational; inputs are the request vector and rr_ptr; output is the one-hot winner.
- The top module holds the FSM, the output register and the slice mux.

## Test plan
- Reset mid-packet: input 1 granted, 2 of 4 beats sent, arstn pulsed → all outputs 0 and FSM IDLE. Inputs 0 and 1 then valid → input 0 wins.
- Single packet: input 2 sends 3 beats (tdata 0xA0, 0xA1, 0xA2, last on the third), m_axis_tready=1 → tvalid at cycles 2–4 with matching data; grant returns to 0 at cycle 4.
- Fairness: all 4 inputs hold 2-beat packets → output order is 0,0,1,1,2,2,3,3,0,0, with one bubble cycle between packets.
- Backpressure: m_axis_tready=0 for 5 cycles mid-packet → output beat held stable and s_native_tready=0 throughout. After release, no beat is lost or duplicated.
- Owner starvation: input 0 granted, its tvalid drops for 3 cycles while input 3 is valid → input 3 is never popped; the packet from input 0 resumes and completes.
- Macro off: inputs 0 and 1 each hold a 2-beat packet → beats interleave 0,1,0,1.
